// File: rtl/writeback_port_arbiter.sv
// writeback_port_arbiter
//   Shares the register-file write port between the pipeline WB stage and
//   the multiply/divide unit. Pipeline writes win; MDU results queue in a
//   small FIFO and drain on cycles the pipeline leaves the port idle. A
//   starvation timer forces a one-cycle WB stall so the FIFO always drains.
//   Pending-write flags let the Decode hazard unit stall on queued results.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   RegWriteW/WriteRegW/ResultW pipeline WB write request
//   MduValid/MduReg/MduData    MDU result push; MduReady = FIFO not full
//   RsD/RtD                    Decode source registers
//   MduPendRsD/MduPendRtD      source register has a queued MDU result
//   RfWE/RfWAddr/RfWData       register-file write port
//   StallWB                    registered one-cycle stall of MEM/WB and earlier
module writeback_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        MduValid,
    output logic        MduReady,
    input  logic [4:0]  MduReg,
    input  logic [31:0] MduData,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    output logic        MduPendRsD,
    output logic        MduPendRtD,
    output logic        RfWE,
    output logic [4:0]  RfWAddr,
    output logic [31:0] RfWData,
    output logic        StallWB
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifoReg  [DEPTH];
    logic [31:0]      fifoData [DEPTH];
    logic [DEPTH-1:0] entryValid;
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starveLeft;

    logic full;
    logic empty;
    logic pipeReq;
    logic push;
    logic pop;
    logic denied;
    logic stallNext;
    logic grantWE;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign MduReady = !full;

    // A stalled WB instruction is re-presented next cycle, so its write is
    // suppressed here to give the port to the FIFO head.
    assign pipeReq = RegWriteW & (WriteRegW != 5'd0) & !StallWB;
    assign push    = MduValid & !full;
    assign pop     = !pipeReq & !empty;
    assign denied  = pipeReq & !empty;

    // Starvation timer counts down from STARVE_LIMIT; the denied cycle that
    // hits terminal count schedules the stall for the following cycle.
    assign stallNext = denied & (starveLeft == SW'(1));

    always_comb begin
        grantWE = 1'b0;
        RfWAddr = 5'd0;
        RfWData = 32'd0;
        if (pipeReq) begin
            grantWE = 1'b1;
            RfWAddr = WriteRegW;
            RfWData = ResultW;
        end else if (!empty) begin
            // A reg-0 entry still pops, it just never reaches the file.
            grantWE = (fifoReg[rdPtr] != 5'd0);
            RfWAddr = fifoReg[rdPtr];
            RfWData = fifoData[rdPtr];
        end
    end

    assign RfWE = grantWE & rst_n;

    // The entry being popped this cycle is still valid here, so it keeps
    // flagging until the write has actually landed.
    always_comb begin
        MduPendRsD = 1'b0;
        MduPendRtD = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (fifoReg[i] == RsD) && (RsD != 5'd0)) begin
                MduPendRsD = 1'b1;
            end
            if (entryValid[i] && (fifoReg[i] == RtD) && (RtD != 5'd0)) begin
                MduPendRtD = 1'b1;
            end
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoReg[wrPtr]  <= MduReg;
            fifoData[wrPtr] <= MduData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
            starveLeft <= SW'(STARVE_LIMIT);
            StallWB    <= 1'b0;
        end else begin
            if (push) begin
                wrPtr             <= wrPtr + AW'(1);
                entryValid[wrPtr] <= 1'b1;
            end
            // Push and pop never address the same slot: that would need the
            // FIFO to be both empty (no pop) and full (no push).
            if (pop) begin
                rdPtr             <= rdPtr + AW'(1);
                entryValid[rdPtr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (empty || pop) begin
                starveLeft <= SW'(STARVE_LIMIT);
            end else if (starveLeft != '0) begin
                starveLeft <= starveLeft - SW'(1);
            end

            StallWB <= stallNext;
        end
    end

endmodule

// File: tb/tb_writeback_port_arbiter.sv
module tb_writeback_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        MduValid;
    logic        MduReady;
    logic [4:0]  MduReg;
    logic [31:0] MduData;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic        MduPendRsD;
    logic        MduPendRtD;
    logic        RfWE;
    logic [4:0]  RfWAddr;
    logic [31:0] RfWData;
    logic        StallWB;

    writeback_port_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RegWriteW(RegWriteW),
        .WriteRegW(WriteRegW),
        .ResultW(ResultW),
        .MduValid(MduValid),
        .MduReady(MduReady),
        .MduReg(MduReg),
        .MduData(MduData),
        .RsD(RsD),
        .RtD(RtD),
        .MduPendRsD(MduPendRsD),
        .MduPendRtD(MduPendRtD),
        .RfWE(RfWE),
        .RfWAddr(RfWAddr),
        .RfWData(RfWData),
        .StallWB(StallWB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected register-file writes, in order: {addr, data}.
    logic [36:0] expQ[$];

    // Reference model: queued MDU results, starvation run length, stall flag.
    logic [36:0] mq[$];
    int          mStarve = 0;
    logic        mStall  = 1'b0;
    int          stallCount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write the DUT presents must match the next
    // expected write.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst_n && RfWE) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected actual=%0d:%0h expected=none t=%0t",
                         RfWAddr, RfWData, $time);
            end else begin
                e = expQ.pop_front();
                if ({RfWAddr, RfWData} !== e) begin
                    errors++;
                    $display("FAIL wr_data actual=%0d:%0h expected=%0d:%0h t=%0t",
                             RfWAddr, RfWData, e[36:32], e[31:0], $time);
                end
            end
        end
    end

    task automatic cycle(input logic rw, input logic [4:0] wr, input logic [31:0] res,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic [4:0] rs, input logic [4:0] rt);
        logic preq;
        logic popM;
        logic pendRs;
        logic pendRt;
        logic nextStall;
        int   sz;
        @(posedge clk);
        #1;
        RegWriteW = rw; WriteRegW = wr; ResultW = res;
        MduValid = mv; MduReg = mr; MduData = md;
        RsD = rs; RtD = rt;

        sz   = mq.size();
        preq = rw && (wr != 5'd0) && !mStall;
        popM = 1'b0;
        if (preq) begin
            expQ.push_back({wr, res});
        end else if (sz > 0) begin
            popM = 1'b1;
            if (mq[0][36:32] != 5'd0) expQ.push_back(mq[0]);
        end
        pendRs = 1'b0;
        pendRt = 1'b0;
        foreach (mq[i]) begin
            if (rs != 5'd0 && mq[i][36:32] == rs) pendRs = 1'b1;
            if (rt != 5'd0 && mq[i][36:32] == rt) pendRt = 1'b1;
        end

        @(negedge clk);
        chk("ready", {31'd0, MduReady}, {31'd0, sz < DEPTH});
        chk("stall", {31'd0, StallWB}, {31'd0, mStall});
        chk("pend_rs", {31'd0, MduPendRsD}, {31'd0, pendRs});
        chk("pend_rt", {31'd0, MduPendRtD}, {31'd0, pendRt});
        if (StallWB) stallCount++;

        if (sz > 0 && preq) begin
            if (mStarve < STARVE_LIMIT) mStarve++;
            nextStall = (mStarve == STARVE_LIMIT);
        end else begin
            mStarve   = 0;
            nextStall = 1'b0;
        end
        if (popM) void'(mq.pop_front());
        if (mv && sz < DEPTH) mq.push_back({mr, md});
        mStall = nextStall;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        chk("missed_writes", expQ.size(), 0);
        RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'h1234_5678;
        MduValid = 1'b0; MduReg = 5'd0; MduData = 32'd0;
        RsD = 5'd6; RtD = 5'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we", {31'd0, RfWE}, 32'd0);
        chk("rst_ready", {31'd0, MduReady}, 32'd1);
        chk("rst_stall", {31'd0, StallWB}, 32'd0);
        chk("rst_pend", {31'd0, MduPendRsD}, 32'd0);
        expQ.delete();
        mq.delete();
        mStarve = 0;
        mStall  = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        RegWriteW = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'd0;
        MduValid = 1'b0; MduReg = 5'd0; MduData = 32'd0;
        RsD = 5'd0; RtD = 5'd0;
        doReset();

        // Single MDU result drains on the next idle WB cycle.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
        idle(2);

        // Fill FIFO under continuous pipeline writes to reg 3; stall forced.
        stallCount = 0;
        cycle(1'b1, 5'd3, 32'hA000_0000, 1'b1, 5'd11, 32'h1111, 5'd11, 5'd12);
        cycle(1'b1, 5'd3, 32'hA000_0001, 1'b1, 5'd12, 32'h2222, 5'd11, 5'd12);
        for (int k = 0; k < 10; k++)
            cycle(1'b1, 5'd3, 32'hA000_0010 + k, 1'b0, 5'd0, 32'd0, 5'd11, 5'd12);
        chk("fill_stalls", stallCount, 2);
        idle(3);

        // Pipeline write to reg 0 leaves the port to the FIFO.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1, 5'd0, 5'd0);
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(1);

        // Reg-0 MDU entry pops silently and never flags.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle(1);

        // Pending flag for reg 9 while the pipeline holds the port.
        cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, 5'd9, 5'd10);
        cycle(1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'd0, 5'd9, 5'd10);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd10);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd10);

        // Reset with a full FIFO discards queued results.
        cycle(1'b1, 5'd3, 32'hB0, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
        cycle(1'b1, 5'd3, 32'hB1, 1'b1, 5'd6, 32'h67, 5'd0, 5'd0);
        doReset();
        idle(4);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) doReset();
            cycle($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(8);
        chk("missed_writes_end", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
